// File: rtl/switch_output_allocator_pkg.sv
// rtl/switch_output_allocator_pkg.sv - shared allocator FSM encodings and default watchdog limit
package switch_output_allocator_pkg;

  typedef enum logic {
    ALLOC_IDLE   = 1'b0,
    ALLOC_LOCKED = 1'b1
  } alloc_state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/switch_output_allocator_rr_arbiter.sv
// rtl/switch_output_allocator_rr_arbiter.sv - combinational round-robin picker starting at ptr_i
module switch_output_allocator_rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  logic [PTR_W-1:0] idx;

  // Walk N slots from ptr_i, wrapping by explicit compare so non-power-of-2 N works.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    idx   = ptr_i;
    for (int k = 0; k < N; k++) begin
      if (!any_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        idx_o      = idx;
        any_o      = 1'b1;
      end
      idx = (idx == PTR_W'(N - 1)) ? '0 : idx + PTR_W'(1);
    end
  end

endmodule

// File: rtl/switch_output_allocator.sv
// rtl/switch_output_allocator.sv - wormhole output allocator; optional lock watchdog via ALLOC_LOCK_TIMEOUT_EN
module switch_output_allocator
  import switch_output_allocator_pkg::*;
#(
  parameter int SWITCH_INPUTS  = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [SWITCH_INPUTS-1:0] req_i,
  input  logic [SWITCH_INPUTS-1:0] tail_i,
  input  logic                     flit_xfer_i,
  output logic [SWITCH_INPUTS-1:0] alloc_out_o,
  output logic                     busy_o,
  output logic                     timeout_o
);

  localparam int PTR_W = $clog2(SWITCH_INPUTS);

  alloc_state_e             state_q;
  logic [SWITCH_INPUTS-1:0] alloc_q;
  logic [PTR_W-1:0]         rr_ptr_q;
  logic [PTR_W-1:0]         winner_q;
  logic [PTR_W-1:0]         rr_ptr_d;
  logic [SWITCH_INPUTS-1:0] pick_gnt;
  logic [PTR_W-1:0]         pick_idx;
  logic                     pick_any;
  logic                     wd_expire;

  switch_output_allocator_rr_arbiter #(
    .N     (SWITCH_INPUTS),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req_i (req_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign rr_ptr_d = (winner_q == PTR_W'(SWITCH_INPUTS - 1)) ? '0 : winner_q + PTR_W'(1);

`ifdef ALLOC_LOCK_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            timeout_q;

  // Fires on the stalled cycle that brings the idle count up to TIMEOUT_CYCLES.
  assign wd_expire = (state_q == ALLOC_LOCKED) && !flit_xfer_i &&
                     (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_expire;
      if ((state_q != ALLOC_LOCKED) || flit_xfer_i || wd_expire) begin
        wd_cnt_q <= '0;
      end else begin
        wd_cnt_q <= wd_cnt_q + WD_W'(1);
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  assign wd_expire = 1'b0;
  // Limit is meaningless without the watchdog; output stays low.
  assign timeout_o = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= ALLOC_IDLE;
      alloc_q  <= '0;
      rr_ptr_q <= '0;
      winner_q <= '0;
    end else begin
      case (state_q)
        ALLOC_IDLE: begin
          if (pick_any) begin
            state_q  <= ALLOC_LOCKED;
            alloc_q  <= pick_gnt;
            winner_q <= pick_idx;
          end
        end
        ALLOC_LOCKED: begin
          if ((flit_xfer_i && tail_i[winner_q]) || wd_expire) begin
            state_q  <= ALLOC_IDLE;
            alloc_q  <= '0;
            rr_ptr_q <= rr_ptr_d;
          end
        end
        default: state_q <= ALLOC_IDLE;
      endcase
    end
  end

  assign alloc_out_o = alloc_q;
  assign busy_o      = |alloc_q;

endmodule

// File: tb/tb_switch_output_allocator.sv
// tb/tb_switch_output_allocator.sv - directed table-driven bench for switch_output_allocator
module tb_switch_output_allocator;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] tail;
  logic       xfer;
  logic [3:0] alloc;
  logic       busy;
  logic       tmo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  switch_output_allocator #(
    .SWITCH_INPUTS  (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .req_i       (req),
    .tail_i      (tail),
    .flit_xfer_i (xfer),
    .alloc_out_o (alloc),
    .busy_o      (busy),
    .timeout_o   (tmo)
  );

  a_no_idle_xfer: assert property (@(posedge clk) disable iff (rst) xfer |-> busy);

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] tail;
    logic       xfer;
    logic [3:0] exp_alloc;
    logic       exp_tmo;
  } vec_t;

  localparam int NV = 34;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] tl, input logic x);
    rst  = r;
    req  = rq;
    tail = tl;
    xfer = x;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    // reset, then 1-flit rotation 0,1,2,3,0 with an idle cycle between grants
    vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[1]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b0};
    vecs[2]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0};
    vecs[3]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b0};
    vecs[4]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0};
    vecs[5]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0100, 1'b0};
    vecs[6]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0};
    vecs[7]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b1000, 1'b0};
    vecs[8]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0};
    vecs[9]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b0};
    vecs[10] = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0};
    // wormhole: input 2 sends 5 flits, stalled 3 cycles, input 1 competing
    vecs[11] = '{1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0};
    vecs[12] = '{1'b0, 4'b0110, 4'b0000, 1'b1, 4'b0100, 1'b0};
    vecs[13] = '{1'b0, 4'b0110, 4'b0010, 1'b0, 4'b0100, 1'b0};
    vecs[14] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0100, 1'b0};
    vecs[15] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0100, 1'b0};
    vecs[16] = '{1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0100, 1'b0};
    vecs[17] = '{1'b0, 4'b0010, 4'b0000, 1'b1, 4'b0100, 1'b0};
    vecs[18] = '{1'b0, 4'b0010, 4'b1011, 1'b1, 4'b0100, 1'b0};
    vecs[19] = '{1'b0, 4'b0010, 4'b0100, 1'b1, 4'b0000, 1'b0};
    vecs[20] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b0};
    vecs[21] = '{1'b0, 4'b0000, 4'b0010, 1'b1, 4'b0000, 1'b0};
    // wrap and skip from rr_ptr=3
    vecs[22] = '{1'b0, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0};
    vecs[23] = '{1'b0, 4'b0000, 4'b0100, 1'b1, 4'b0000, 1'b0};
    vecs[24] = '{1'b0, 4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b0};
    vecs[25] = '{1'b0, 4'b0011, 4'b0001, 1'b1, 4'b0000, 1'b0};
    vecs[26] = '{1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b0};
    vecs[27] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b0};
    // reset while locked on input 1: lock dropped, rr_ptr back to 0
    vecs[28] = '{1'b1, 4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[29] = '{1'b0, 4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b0};
    vecs[30] = '{1'b0, 4'b0000, 4'b0001, 1'b1, 4'b0000, 1'b0};
    vecs[31] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[32] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[33] = '{1'b0, 4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b0};

    rst = 1'b1; req = '0; tail = '0; xfer = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].tail, vecs[i].xfer);
      check($sformatf("vec%0d_alloc", i), alloc, vecs[i].exp_alloc);
      check($sformatf("vec%0d_busy", i), {3'b000, busy}, {3'b000, |vecs[i].exp_alloc});
      check($sformatf("vec%0d_timeout", i), {3'b000, tmo}, {3'b000, vecs[i].exp_tmo});
    end

    // Locked on input 3 (rr_ptr=1); now starve the lock of transfers.
`ifdef ALLOC_LOCK_TIMEOUT_EN
    begin
      int pulses = 0;
      for (int c = 1; c <= 7; c++) begin
        step(1'b0, 4'b1111, 4'b0000, 1'b0);
        if (tmo) pulses++;
        check($sformatf("wd_hold%0d", c), alloc, 4'b1000);
      end
      step(1'b0, 4'b1111, 4'b0000, 1'b0);
      if (tmo) pulses++;
      check("wd_release_alloc", alloc, 4'b0000);
      check("wd_release_pulse", {3'b000, tmo}, 4'b0001);
      step(1'b0, 4'b1111, 4'b0000, 1'b0);
      if (tmo) pulses++;
      check("wd_ptr_advanced", alloc, 4'b0001);
      check("wd_pulse_count", 4'(pulses), 4'd1);
    end
`else
    for (int c = 1; c <= 120; c++) begin
      step(1'b0, 4'b1111, 4'b0000, 1'b0);
      check($sformatf("nowd_hold%0d", c), alloc, 4'b1000);
      check($sformatf("nowd_tmo%0d", c), {3'b000, tmo}, 4'b0000);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
